// File: rtl/apb_master_bridge.sv
// APB requester: turns single valid/ready requests into APB SETUP/ACCESS transfers
// to the GPIO or UART slave and returns read data / error on a valid/ready response port.
module apb_master_bridge #(
  parameter logic [31:0] GPIO_BASE = 32'h4000_0000,
  parameter logic [31:0] UART_BASE = 32'h4000_1000,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_prot,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] PADDR,
  output logic [31:0] PWDATA,
  output logic        PWRITE,
  output logic [1:0]  PSEL,
  output logic        PENABLE,
  output logic [2:0]  PPROT,
  input  logic [31:0] PRDATA,
  input  logic        PREADY,
  input  logic        PSLVERR
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] RESP   = 2'd3;

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic [1:0]       state;
  logic [CNT_W-1:0] wait_cnt;
  logic             hit_gpio;
  logic             hit_uart;
  logic             timed_out;

  // Region match is on the 4 KiB page only; the offset passes through untouched.
  assign hit_gpio  = (req_addr[31:12] == GPIO_BASE[31:12]);
  assign hit_uart  = (req_addr[31:12] == UART_BASE[31:12]);
  assign timed_out = (TIMEOUT != 0) && (wait_cnt == CNT_LAST) && !PREADY;

  assign req_ready = (state == IDLE) && !PRESET;
  assign rsp_valid = (state == RESP);

  // NOTE: every register here is written with <= so all of them see the
  // pre-edge values of each other; mixing in = would make results order-dependent.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      PADDR     <= '0;
      PWDATA    <= '0;
      PWRITE    <= 1'b0;
      PPROT     <= '0;
      PSEL      <= '0;
      PENABLE   <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            if (hit_gpio || hit_uart) begin
              PADDR  <= req_addr;
              PWDATA <= req_wdata;
              PWRITE <= req_write;
              PPROT  <= req_prot;
              // GPIO wins if both bases were configured onto the same page, keeping PSEL one-hot.
              PSEL   <= hit_gpio ? 2'b01 : 2'b10;
              state  <= SETUP;
            end else begin
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
              state     <= RESP;
            end
          end
        end

        SETUP: begin
          PENABLE <= 1'b1;
          state   <= ACCESS;
        end

        ACCESS: begin
          if (PREADY) begin
            rsp_err   <= PSLVERR;
            rsp_rdata <= (!PWRITE && !PSLVERR) ? PRDATA : 32'h0;
            PSEL      <= '0;
            PENABLE   <= 1'b0;
            state     <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
            if (timed_out) begin
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
              PSEL      <= '0;
              PENABLE   <= 1'b0;
              state     <= RESP;
            end
          end
        end

        RESP: begin
          if (rsp_ready) begin
            wait_cnt <= '0;
            state    <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge: GPIO/UART transfers, unmapped access,
// timeout, slave error, response backpressure and reset abort.
module tb_apb_master_bridge;

  logic        PCLK;
  logic        PRESET;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_prot;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic        PWRITE;
  logic [1:0]  PSEL;
  logic        PENABLE;
  logic [2:0]  PPROT;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  int passed;
  int total;

  apb_master_bridge #(
    .GPIO_BASE(32'h4000_0000),
    .UART_BASE(32'h4000_1000),
    .TIMEOUT  (16)
  ) dut (
    .PCLK     (PCLK),
    .PRESET   (PRESET),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .req_prot (req_prot),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .PADDR    (PADDR),
    .PWDATA   (PWDATA),
    .PWRITE   (PWRITE),
    .PSEL     (PSEL),
    .PENABLE  (PENABLE),
    .PPROT    (PPROT),
    .PRDATA   (PRDATA),
    .PREADY   (PREADY),
    .PSLVERR  (PSLVERR)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  // Presents one request for a single cycle; returns one cycle after acceptance (N+1).
  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] wd, input logic [2:0] p);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = wd;
    req_prot  = p;
    total++;
    if (req_ready !== 1'b1) $display("FAIL issue_ready: req_ready=%b expected 1", req_ready);
    else passed++;
    tick();
    req_valid = 1'b0;
  endtask

  // Acts as the slave from N+1 until rsp_valid; lat counts cycles since acceptance.
  task automatic wait_rsp(input int waits, input logic [31:0] rd, input logic err,
                          output int lat, output int acc);
    lat = 1;
    acc = 0;
    while (rsp_valid !== 1'b1 && lat < 200) begin
      if (PENABLE === 1'b1) begin
        PREADY  = (acc >= waits);
        PRDATA  = rd;
        PSLVERR = err && (acc >= waits);
        acc++;
      end else begin
        PREADY  = 1'b0;
        PSLVERR = 1'b0;
      end
      tick();
      lat++;
    end
    PREADY  = 1'b0;
    PSLVERR = 1'b0;
    total++;
    if (rsp_valid !== 1'b1) $display("FAIL rsp_timeout: rsp_valid=%b after %0d cycles expected 1", rsp_valid, lat);
    else passed++;
  endtask

  // Consumes the pending response and checks the bridge returns to IDLE.
  task automatic finish_rsp();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    total++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1)
      $display("FAIL rsp_handshake: rsp_valid=%b req_ready=%b expected 0/1", rsp_valid, req_ready);
    else passed++;
  endtask

  task automatic test_reset();
    PRESET = 1'b1;
    tick();
    tick();
    total++;
    if ({PSEL, PENABLE, PWRITE, PPROT, rsp_valid, rsp_err, req_ready} !== 10'b0 ||
        PADDR !== 32'h0 || PWDATA !== 32'h0 || rsp_rdata !== 32'h0)
      $display("FAIL reset_outputs: psel=%b pen=%b paddr=%h pwdata=%h rsp_valid=%b req_ready=%b expected all 0",
               PSEL, PENABLE, PADDR, PWDATA, rsp_valid, req_ready);
    else passed++;
    PRESET = 1'b0;
    tick();
    total++;
    if (req_ready !== 1'b1) $display("FAIL reset_release_ready: req_ready=%b expected 1", req_ready);
    else passed++;
  endtask

  task automatic test_write_gpio();
    issue(1'b1, 32'h4000_0004, 32'h0000_00A5, 3'b010);
    total++;
    if (PSEL !== 2'b01 || PENABLE !== 1'b0 || PADDR !== 32'h4000_0004 ||
        PWDATA !== 32'h0000_00A5 || PWRITE !== 1'b1 || PPROT !== 3'b010)
      $display("FAIL wr_setup: psel=%b pen=%b paddr=%h pwdata=%h pwrite=%b pprot=%b expected 01/0/40000004/000000a5/1/010",
               PSEL, PENABLE, PADDR, PWDATA, PWRITE, PPROT);
    else passed++;
    tick();
    total++;
    if (PSEL !== 2'b01 || PENABLE !== 1'b1 || PADDR !== 32'h4000_0004)
      $display("FAIL wr_access: psel=%b pen=%b paddr=%h expected 01/1/40000004", PSEL, PENABLE, PADDR);
    else passed++;
    PREADY = 1'b1;
    tick();
    PREADY = 1'b0;
    total++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0 || PSEL !== 2'b00 || PENABLE !== 1'b0)
      $display("FAIL wr_resp: rsp_valid=%b err=%b rdata=%h psel=%b pen=%b expected 1/0/00000000/00/0",
               rsp_valid, rsp_err, rsp_rdata, PSEL, PENABLE);
    else passed++;
    finish_rsp();
  endtask

  task automatic test_read_uart_waits();
    int lat;
    int acc;
    issue(1'b0, 32'h4000_1008, 32'h0, 3'b000);
    total++;
    if (PSEL !== 2'b10 || PWRITE !== 1'b0) $display("FAIL rd_uart_psel: psel=%b pwrite=%b expected 10/0", PSEL, PWRITE);
    else passed++;
    wait_rsp(3, 32'h0000_005A, 1'b0, lat, acc);
    total++;
    if (lat !== 6) $display("FAIL rd_uart_latency: rsp_valid at N+%0d expected N+6", lat);
    else passed++;
    total++;
    if (rsp_rdata !== 32'h0000_005A || rsp_err !== 1'b0)
      $display("FAIL rd_uart_data: rdata=%h err=%b expected 0000005a/0", rsp_rdata, rsp_err);
    else passed++;
    finish_rsp();
  endtask

  task automatic test_unmapped();
    issue(1'b0, 32'h5000_0000, 32'h1111_1111, 3'b111);
    total++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0 || PSEL !== 2'b00)
      $display("FAIL unmapped_resp: rsp_valid=%b err=%b rdata=%h psel=%b expected 1/1/00000000/00",
               rsp_valid, rsp_err, rsp_rdata, PSEL);
    else passed++;
    total++;
    if (PADDR !== 32'h4000_1008 || PPROT !== 3'b000)
      $display("FAIL unmapped_hold: paddr=%h pprot=%b expected 40001008/000", PADDR, PPROT);
    else passed++;
    finish_rsp();
  endtask

  task automatic test_timeout();
    int lat;
    int acc;
    issue(1'b1, 32'h4000_0010, 32'hCAFE_0001, 3'b001);
    wait_rsp(1000, 32'h0, 1'b0, lat, acc);
    total++;
    if (acc !== 16 || lat !== 18)
      $display("FAIL timeout_cycles: access=%0d latency=N+%0d expected 16/N+18", acc, lat);
    else passed++;
    total++;
    if (rsp_err !== 1'b1 || rsp_rdata !== 32'h0 || PSEL !== 2'b00 || PENABLE !== 1'b0)
      $display("FAIL timeout_resp: err=%b rdata=%h psel=%b pen=%b expected 1/00000000/00/0",
               rsp_err, rsp_rdata, PSEL, PENABLE);
    else passed++;
    finish_rsp();
  endtask

  task automatic test_slave_error();
    int lat;
    int acc;
    issue(1'b0, 32'h4000_0FFC, 32'h0, 3'b000);
    wait_rsp(1, 32'hDEAD_BEEF, 1'b1, lat, acc);
    total++;
    if (lat !== 4 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0)
      $display("FAIL slverr_resp: latency=N+%0d err=%b rdata=%h expected N+4/1/00000000", lat, rsp_err, rsp_rdata);
    else passed++;
    finish_rsp();
  endtask

  task automatic test_backpressure();
    int lat;
    int acc;
    issue(1'b0, 32'h4000_0020, 32'h0, 3'b000);
    wait_rsp(0, 32'h1234_5678, 1'b0, lat, acc);
    total++;
    if (lat !== 3) $display("FAIL bp_latency: rsp_valid at N+%0d expected N+3", lat);
    else passed++;
    req_valid = 1'b1;
    req_addr  = 32'h4000_1000;
    PRDATA    = 32'hFFFF_FFFF;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h1234_5678 || req_ready !== 1'b0 || PSEL !== 2'b00)
        $display("FAIL bp_hold_%0d: rsp_valid=%b rdata=%h req_ready=%b psel=%b expected 1/12345678/0/00",
                 i, rsp_valid, rsp_rdata, req_ready, PSEL);
      else passed++;
    end
    req_valid = 1'b0;
    finish_rsp();
  endtask

  task automatic test_reset_abort();
    int lat;
    int acc;
    issue(1'b1, 32'h4000_0008, 32'h0000_0077, 3'b000);
    tick();
    total++;
    if (PENABLE !== 1'b1 || PSEL !== 2'b01)
      $display("FAIL abort_in_access: pen=%b psel=%b expected 1/01", PENABLE, PSEL);
    else passed++;
    #1 PRESET = 1'b1;
    #1;
    total++;
    if (PSEL !== 2'b00 || PENABLE !== 1'b0 || req_ready !== 1'b0 || rsp_valid !== 1'b0)
      $display("FAIL abort_async: psel=%b pen=%b req_ready=%b rsp_valid=%b expected 00/0/0/0",
               PSEL, PENABLE, req_ready, rsp_valid);
    else passed++;
    #1 PRESET = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (rsp_valid !== 1'b0 || PSEL !== 2'b00)
        $display("FAIL abort_quiet_%0d: rsp_valid=%b psel=%b expected 0/00", i, rsp_valid, PSEL);
      else passed++;
    end
    issue(1'b1, 32'h4000_1004, 32'h0000_0042, 3'b000);
    total++;
    if (PSEL !== 2'b10) $display("FAIL abort_next_psel: psel=%b expected 10", PSEL);
    else passed++;
    wait_rsp(0, 32'h0, 1'b0, lat, acc);
    total++;
    if (lat !== 3 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0)
      $display("FAIL abort_next_resp: latency=N+%0d err=%b rdata=%h expected N+3/0/00000000", lat, rsp_err, rsp_rdata);
    else passed++;
    finish_rsp();
  endtask

  initial begin
    passed    = 0;
    total     = 0;
    PRESET    = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_prot  = '0;
    rsp_ready = 1'b0;
    PRDATA    = '0;
    PREADY    = 1'b0;
    PSLVERR   = 1'b0;
    #1;

    test_reset();
    test_write_gpio();
    test_read_uart_waits();
    test_unmapped();
    test_timeout();
    test_slave_error();
    test_backpressure();
    test_reset_abort();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
